mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Sits downstream of the CPU top level. It merges the instruction-fetch port and the data load/store port into one external 64-bit memory bus.
- The external bus carries mem_addr, mem_dout, mem_din, mem_addr_valid, mem_dout_write and mem_din_ready.
- Data requests have fixed priority over fetches. A per-transaction timeout prevents a hung bus from stalling the pipeline forever.

Parameters:
- ADDR_W, 64, width of all address ports.
- DATA_W, 64, width of all data ports.
- TIMEOUT_CYCLES, 255, cycles to wait for mem_din_ready before aborting; 0 disables the timeout.

Ports:
- clk  in  1  CPU clock, rising edge.
- rst_n  in  1  Asynchronous active-low reset.
- imem_addr  in  ADDR_W  Fetch address, sampled with imem_addr_valid.
- imem_addr_valid  in  1  Fetch request strobe.
- imem_data  out  DATA_W  Fetched word.
- imem_data_valid  out  1  One-cycle pulse; imem_data is valid.
- dmem_addr  in  ADDR_W  Load/store address.
- dmem_dout  in  DATA_W  Store data from the CPU.
- dmem_write_width  in  2  Store width code: 0=64, 1=32, 2=16, 3=8 bits.
- dmem_rstrobe  in  1  Load request strobe.
- dmem_wstrobe  in  1  Store request strobe.
- dmem_din  out  DATA_W  Load data to the CPU.
- dmem_cycle_complete  out  1  One-cycle pulse; load or store finished.
- mem_addr  out  ADDR_W  External address.
- mem_dout  out  DATA_W  External write data.
- mem_write_width  out  2  External write width code.
- mem_addr_valid  out  1  External request active.
- mem_dout_write  out  1  External request is a write.
- mem_din  in  DATA_W  External read data, valid with mem_din_ready.
- mem_din_ready  in  1  External completion, one cycle.
- bus_error  out  1  One-cycle pulse when a transaction times out.

Behaviour:
- Reset (async, rst_n low):
  - All outputs go to 0, the FSM goes to IDLE, and the pending flags and timeout counter clear.
  - Reset in mid-transaction abandons it with no response pulse.
- Request capture:
  - A strobe sampled high sets that port's pending flag and latches its addr, data and width.
  - A strobe arriving while that port is already pending or in service is ignored; the latched values are not overwritten.
  - dmem_rstrobe and dmem_wstrobe high together is treated as a write.
- FSM states: IDLE, FETCH, DREAD, DWRITE.
  - IDLE:
    - Candidates are the pending flags OR'd with the strobes of the current cycle.
    - Data pending goes to DREAD or DWRITE; otherwise fetch pending goes to FETCH; otherwise stay in IDLE.
    - On the transition edge, register mem_addr, mem_dout, mem_write_width and mem_dout_write, and set mem_addr_valid=1.
  - Minimum latency: a strobe at edge N gives mem_addr_valid=1 after edge N.
  - Busy states:
    - mem_addr, mem_dout, mem_write_width, mem_dout_write and mem_addr_valid stay stable until completion.
    - mem_din_ready sampled high at edge M:
      - After M: mem_addr_valid=0, mem_dout_write=0, the served pending flag clears, and the FSM returns to IDLE.
      - After M, for FETCH: imem_data=mem_din and imem_data_valid=1 for one cycle.
      - After M, for DREAD: dmem_din=mem_din and dmem_cycle_complete=1 for one cycle.
      - After M, for DWRITE: dmem_cycle_complete=1 for one cycle; dmem_din is unchanged.
    - Back-to-back transactions always have one idle cycle (mem_addr_valid=0) between them.
  - mem_din_ready while in IDLE is ignored.
  - imem_data and dmem_din hold their last value between pulses.
- Timeout:
  - The counter clears on entry to a busy state and increments each cycle that mem_din_ready is low.
  - On reaching TIMEOUT_CYCLES, the FSM completes exactly as if mem_din_ready were high, with response data forced to 0, and bus_error pulses with the same timing as the response pulse.
  - A mem_din_ready arriving in the same cycle as the terminal count wins: real data is returned and there is no error.
- Starvation: fetch waits while data requests keep arriving. This is acceptable because the pipeline has at most one data access outstanding.
- A new strobe for a port whose response pulses in the same cycle is accepted, because the pending flag is free after that edge.

Decomposition:
- Shared package raisin64_mem_pkg holds:
  - the FSM state encoding;
  - the width-code constants W64, W32, W16, W8;
  - a default TIMEOUT constant.
- One natural sub-module, mem_timeout_counter, with clear, enable and terminal-count outputs. Everything else is inline.

Test Plan:
- Single fetch at addr 0x40, memory answers 3 cycles later with 0xDEADBEEF_0000_0001 -> one imem_data_valid pulse carrying that word; mem_dout_write=0 throughout.
- dmem_wstrobe to addr 0x10, data 0x1122334455667788, width 2 -> mem_dout_write=1, mem_write_width=2 and mem_dout stable until ready; a single dmem_cycle_complete pulse.
- imem_addr_valid and dmem_rstrobe in the same cycle -> DREAD serviced first, then one idle cycle, then FETCH; each response pulses exactly once, in that order.
- Memory never answers, TIMEOUT_CYCLES=4 -> the response pulse comes 5 cycles after mem_addr_valid rises, with data 0 and bus_error=1 in the same cycle.
- Repeat imem_addr_valid at 0x80 during an in-flight fetch of 0x40 -> ignored; mem_addr stays 0x40; only one fetch response.
- rst_n low while in DWRITE -> all outputs 0 immediately; no dmem_cycle_complete; after release, a new request is served normally.

Source files
------------

// File: rtl/raisin64_mem_pkg.sv
// rtl/raisin64_mem_pkg.sv - shared types and constants for the memory port arbiter
package raisin64_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DREAD  = 2'd2,
    ST_DWRITE = 2'd3
  } arb_state_t;

  localparam logic [1:0] W64 = 2'd0;
  localparam logic [1:0] W32 = 2'd1;
  localparam logic [1:0] W16 = 2'd2;
  localparam logic [1:0] W8  = 2'd3;

  localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_timeout_counter.sv
// rtl/mem_timeout_counter.sv - saturating per-transaction timeout counter
// tc is held once the count reaches TIMEOUT_CYCLES; a TIMEOUT_CYCLES of 0 never fires.
module mem_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !tc) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (TIMEOUT_CYCLES != 0) && (count == CNT_W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - merges fetch and load/store ports onto one memory bus
// Data has fixed priority over fetch; a timeout completes a hung transaction with zero data.
module mem_port_arbiter
  import raisin64_mem_pkg::*;
#(
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_addr_valid,
  output logic [DATA_W-1:0] imem_data,
  output logic              imem_data_valid,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0] dmem_dout,
  input  logic [1:0]        dmem_write_width,
  input  logic              dmem_rstrobe,
  input  logic              dmem_wstrobe,
  output logic [DATA_W-1:0] dmem_din,
  output logic              dmem_cycle_complete,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dout,
  output logic [1:0]        mem_write_width,
  output logic              mem_addr_valid,
  output logic              mem_dout_write,
  input  logic [DATA_W-1:0] mem_din,
  input  logic              mem_din_ready,
  output logic              bus_error
);

  arb_state_t        state;
  logic              i_pend, d_pend, d_we_q;
  logic [ADDR_W-1:0] i_addr_q, d_addr_q;
  logic [DATA_W-1:0] d_data_q;
  logic [1:0]        d_width_q;

  logic              busy, done, tc, d_req, i_req, d_we;
  logic [ADDR_W-1:0] i_addr_n, d_addr_n;
  logic [DATA_W-1:0] d_data_n, rdata;
  logic [1:0]        d_width_n;

  // Idle arbitration sees this cycle's strobes as well as latched requests.
  assign d_req     = d_pend | dmem_rstrobe | dmem_wstrobe;
  assign i_req     = i_pend | imem_addr_valid;
  assign d_we      = d_pend ? d_we_q    : dmem_wstrobe;
  assign d_addr_n  = d_pend ? d_addr_q  : dmem_addr;
  assign d_data_n  = d_pend ? d_data_q  : dmem_dout;
  assign d_width_n = d_pend ? d_width_q : dmem_write_width;
  assign i_addr_n  = i_pend ? i_addr_q  : imem_addr;

  assign busy  = (state != ST_IDLE);
  assign done  = busy && (mem_din_ready || tc);
  assign rdata = mem_din_ready ? mem_din : '0;

  mem_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!busy),
    .enable (busy && !mem_din_ready),
    .tc     (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= ST_IDLE;
      i_pend              <= 1'b0;
      d_pend              <= 1'b0;
      d_we_q              <= 1'b0;
      i_addr_q            <= '0;
      d_addr_q            <= '0;
      d_data_q            <= '0;
      d_width_q           <= W64;
      imem_data           <= '0;
      imem_data_valid     <= 1'b0;
      dmem_din            <= '0;
      dmem_cycle_complete <= 1'b0;
      mem_addr            <= '0;
      mem_dout            <= '0;
      mem_write_width     <= W64;
      mem_addr_valid      <= 1'b0;
      mem_dout_write      <= 1'b0;
      bus_error           <= 1'b0;
    end else begin
      imem_data_valid     <= 1'b0;
      dmem_cycle_complete <= 1'b0;
      bus_error           <= 1'b0;

      if (imem_addr_valid && !i_pend) begin
        i_pend   <= 1'b1;
        i_addr_q <= imem_addr;
      end
      if ((dmem_rstrobe || dmem_wstrobe) && !d_pend) begin
        d_pend    <= 1'b1;
        d_we_q    <= dmem_wstrobe;
        d_addr_q  <= dmem_addr;
        d_data_q  <= dmem_dout;
        d_width_q <= dmem_write_width;
      end

      case (state)
        ST_IDLE: begin
          if (d_req) begin
            state           <= d_we ? ST_DWRITE : ST_DREAD;
            mem_addr        <= d_addr_n;
            mem_dout        <= d_we ? d_data_n : '0;
            mem_write_width <= d_we ? d_width_n : W64;
            mem_dout_write  <= d_we;
            mem_addr_valid  <= 1'b1;
          end else if (i_req) begin
            state           <= ST_FETCH;
            mem_addr        <= i_addr_n;
            mem_dout        <= '0;
            mem_write_width <= W64;
            mem_dout_write  <= 1'b0;
            mem_addr_valid  <= 1'b1;
          end
        end
        default: begin
          if (done) begin
            state          <= ST_IDLE;
            mem_addr_valid <= 1'b0;
            mem_dout_write <= 1'b0;
            bus_error      <= !mem_din_ready;
            if (state == ST_FETCH) begin
              i_pend          <= 1'b0;
              imem_data       <= rdata;
              imem_data_valid <= 1'b1;
            end else begin
              d_pend              <= 1'b0;
              dmem_cycle_complete <= 1'b1;
              if (state == ST_DREAD) dmem_din <= rdata;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] imem_addr, dmem_addr, dmem_dout, mem_din;
  logic        imem_addr_valid, dmem_rstrobe, dmem_wstrobe, mem_din_ready;
  logic [1:0]  dmem_write_width;
  logic [63:0] imem_data, dmem_din, mem_addr, mem_dout;
  logic        imem_data_valid, dmem_cycle_complete, mem_addr_valid, mem_dout_write, bus_error;
  logic [1:0]  mem_write_width;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_addr_valid(imem_addr_valid),
    .imem_data(imem_data), .imem_data_valid(imem_data_valid),
    .dmem_addr(dmem_addr), .dmem_dout(dmem_dout), .dmem_write_width(dmem_write_width),
    .dmem_rstrobe(dmem_rstrobe), .dmem_wstrobe(dmem_wstrobe),
    .dmem_din(dmem_din), .dmem_cycle_complete(dmem_cycle_complete),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_write_width(mem_write_width),
    .mem_addr_valid(mem_addr_valid), .mem_dout_write(mem_dout_write),
    .mem_din(mem_din), .mem_din_ready(mem_din_ready), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  // Transaction-level model: one request slot per port, one transaction on the bus.
  bit          mi_pend = 0, md_pend = 0, md_we = 0;
  logic [63:0] mi_addr = 0, md_addr = 0, md_data = 0;
  logic [1:0]  md_w = 0;
  int          cur = 0;   // 0 none, 1 fetch, 2 load, 3 store
  int          age = 0;   // bus cycles since the request was issued
  logic        e_valid = 0, e_write = 0, e_ivalid = 0, e_dcc = 0, e_err = 0;
  logic [63:0] e_addr = 0, e_dout = 0, e_idata = 0, e_ddin = 0;
  logic [1:0]  e_ww = 0;
  logic [63:0] resp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mi_pend = 0; md_pend = 0; cur = 0; age = 0;
      e_valid = 0; e_write = 0; e_ivalid = 0; e_dcc = 0; e_err = 0;
      e_addr = 0; e_dout = 0; e_idata = 0; e_ddin = 0; e_ww = 0;
    end else begin
      e_ivalid = 0; e_dcc = 0; e_err = 0;
      if (imem_addr_valid && !mi_pend) begin mi_pend = 1; mi_addr = imem_addr; end
      if ((dmem_rstrobe || dmem_wstrobe) && !md_pend) begin
        md_pend = 1; md_we = dmem_wstrobe; md_addr = dmem_addr;
        md_data = dmem_dout; md_w = dmem_write_width;
      end
      if (cur == 0) begin
        if (md_pend) begin
          cur = md_we ? 3 : 2; age = 0; e_valid = 1; e_write = md_we;
          e_addr = md_addr; e_dout = md_data; e_ww = md_w;
        end else if (mi_pend) begin
          cur = 1; age = 0; e_valid = 1; e_write = 0; e_addr = mi_addr;
        end
      end else if (mem_din_ready || age == TMO) begin
        resp = mem_din_ready ? mem_din : 64'd0;
        if (cur == 1) begin mi_pend = 0; e_ivalid = 1; e_idata = resp; end
        else begin md_pend = 0; e_dcc = 1; if (cur == 2) e_ddin = resp; end
        e_err = !mem_din_ready; e_valid = 0; e_write = 0; cur = 0;
      end else begin
        age++;
      end
    end
  end

  bit          started = 0;
  int          cyc = 0, i_cnt = 0, d_cnt = 0, err_cnt = 0, rise_cnt = 0;
  int          i_cyc = 0, d_cyc = 0, err_cyc = 0, rise_cyc = 0;
  logic [63:0] i_last = 0, d_last = 0, rise_addr = 0, last_wdout = 0;
  logic [1:0]  last_ww = 0;
  int          wr_seen = 0;
  logic        prev_valid = 0;

  always @(negedge clk) if (started) begin
    cyc++;
    check("mem_addr_valid", 64'(mem_addr_valid), 64'(e_valid));
    check("mem_dout_write", 64'(mem_dout_write), 64'(e_write));
    check("imem_data_valid", 64'(imem_data_valid), 64'(e_ivalid));
    check("dmem_cycle_complete", 64'(dmem_cycle_complete), 64'(e_dcc));
    check("bus_error", 64'(bus_error), 64'(e_err));
    check("imem_data", imem_data, e_idata);
    check("dmem_din", dmem_din, e_ddin);
    if (e_valid) check("mem_addr", mem_addr, e_addr);
    if (e_write) begin
      check("mem_dout", mem_dout, e_dout);
      check("mem_write_width", 64'(mem_write_width), 64'(e_ww));
    end
    if (imem_data_valid) begin i_cnt++; i_cyc = cyc; i_last = imem_data; end
    if (dmem_cycle_complete) begin d_cnt++; d_cyc = cyc; d_last = dmem_din; end
    if (bus_error) begin err_cnt++; err_cyc = cyc; end
    if (mem_addr_valid && !prev_valid) begin rise_cnt++; rise_cyc = cyc; rise_addr = mem_addr; end
    if (mem_dout_write) begin wr_seen++; last_wdout = mem_dout; last_ww = mem_write_width; end
    prev_valid = mem_addr_valid;
  end

  task automatic fetch_req(input logic [63:0] a);
    imem_addr = a; imem_addr_valid = 1;
    @(negedge clk); imem_addr_valid = 0;
  endtask

  task automatic data_req(input logic [63:0] a, input logic [63:0] d, input logic [1:0] w, input logic we);
    dmem_addr = a; dmem_dout = d; dmem_write_width = w; dmem_wstrobe = we; dmem_rstrobe = !we;
    @(negedge clk); dmem_wstrobe = 0; dmem_rstrobe = 0;
  endtask

  task automatic respond(input logic [63:0] d, input int delay);
    int n = 0;
    while (!mem_addr_valid && n < 50) begin @(negedge clk); n++; end
    if (!mem_addr_valid) check("respond_wait_timeout", 64'(mem_addr_valid), 64'd1);
    repeat (delay) @(negedge clk);
    mem_din = d; mem_din_ready = 1;
    @(negedge clk); mem_din_ready = 0;
  endtask

  int i0, d0, e0, r0, w0;

  initial begin
    imem_addr = 0; imem_addr_valid = 0; dmem_addr = 0; dmem_dout = 0;
    dmem_write_width = 0; dmem_rstrobe = 0; dmem_wstrobe = 0; mem_din = 0; mem_din_ready = 0;
    repeat (2) @(negedge clk);
    started = 1;
    #1;
    check("reset_mem_addr_valid", 64'(mem_addr_valid), 64'd0);
    check("reset_mem_addr", mem_addr, 64'd0);
    check("reset_imem_data", imem_data, 64'd0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);

    // single fetch, answered 3 cycles after issue
    i0 = i_cnt; w0 = wr_seen;
    fetch_req(64'h40);
    respond(64'hDEADBEEF_0000_0001, 3);
    repeat (2) @(negedge clk); #1;
    check("fetch_pulses", 64'(i_cnt - i0), 64'd1);
    check("fetch_data", i_last, 64'hDEADBEEF_0000_0001);
    check("fetch_no_write", 64'(wr_seen - w0), 64'd0);
    check("fetch_addr", rise_addr, 64'h40);

    // 16-bit store
    @(negedge clk);
    d0 = d_cnt;
    data_req(64'h10, 64'h1122334455667788, 2'd2, 1'b1);
    respond(64'h0, 2);
    repeat (2) @(negedge clk); #1;
    check("store_pulses", 64'(d_cnt - d0), 64'd1);
    check("store_dout", last_wdout, 64'h1122334455667788);
    check("store_width", 64'(last_ww), 64'd2);
    check("store_addr", rise_addr, 64'h10);

    // simultaneous fetch and load: load first, idle gap, then fetch
    @(negedge clk);
    i0 = i_cnt; d0 = d_cnt; r0 = rise_cnt;
    imem_addr = 64'h100; imem_addr_valid = 1; dmem_addr = 64'h200; dmem_rstrobe = 1;
    @(negedge clk); imem_addr_valid = 0; dmem_rstrobe = 0;
    respond(64'hAAAA_0000_0000_0002, 1);
    respond(64'hBBBB_0000_0000_0003, 1);
    repeat (2) @(negedge clk); #1;
    check("prio_load_pulses", 64'(d_cnt - d0), 64'd1);
    check("prio_fetch_pulses", 64'(i_cnt - i0), 64'd1);
    check("prio_order", 64'(i_cyc > d_cyc), 64'd1);
    check("prio_load_data", d_last, 64'hAAAA_0000_0000_0002);
    check("prio_fetch_data", i_last, 64'hBBBB_0000_0000_0003);
    check("prio_fetch_addr", rise_addr, 64'h100);
    check("prio_rises", 64'(rise_cnt - r0), 64'd2);

    // load that never completes: timeout with zero data
    @(negedge clk);
    d0 = d_cnt; e0 = err_cnt; mem_din = 64'hFFFF_FFFF_FFFF_FFFF;
    data_req(64'h300, 64'h0, 2'd0, 1'b0);
    repeat (10) @(negedge clk); #1;
    check("tmo_pulses", 64'(d_cnt - d0), 64'd1);
    check("tmo_latency", 64'(d_cyc - rise_cyc), 64'd5);
    check("tmo_error", 64'(err_cnt - e0), 64'd1);
    check("tmo_error_align", 64'(err_cyc), 64'(d_cyc));
    check("tmo_data", d_last, 64'd0);

    // ready on the terminal-count cycle wins
    @(negedge clk);
    i0 = i_cnt; e0 = err_cnt;
    fetch_req(64'h600);
    respond(64'h1234_5678_9ABC_DEF0, 4);
    repeat (2) @(negedge clk); #1;
    check("tie_pulses", 64'(i_cnt - i0), 64'd1);
    check("tie_no_error", 64'(err_cnt - e0), 64'd0);
    check("tie_data", i_last, 64'h1234_5678_9ABC_DEF0);

    // repeat fetch strobe while in flight is ignored
    @(negedge clk);
    i0 = i_cnt; r0 = rise_cnt;
    fetch_req(64'h40);
    @(negedge clk);
    fetch_req(64'h80);
    respond(64'h5555, 1);
    repeat (4) @(negedge clk); #1;
    check("dup_pulses", 64'(i_cnt - i0), 64'd1);
    check("dup_rises", 64'(rise_cnt - r0), 64'd1);
    check("dup_addr", rise_addr, 64'h40);

    // reset during a store abandons it
    @(negedge clk);
    d0 = d_cnt;
    data_req(64'h700, 64'hCAFE, 2'd1, 1'b1);
    @(negedge clk);
    #3 rst_n = 0;
    #1;
    check("rst_mid_valid", 64'(mem_addr_valid), 64'd0);
    check("rst_mid_write", 64'(mem_dout_write), 64'd0);
    check("rst_mid_addr", mem_addr, 64'd0);
    check("rst_mid_dout", mem_dout, 64'd0);
    check("rst_mid_dmem_din", dmem_din, 64'd0);
    @(negedge clk); @(negedge clk); rst_n = 1;
    @(negedge clk); #1;
    check("rst_no_complete", 64'(d_cnt - d0), 64'd0);
    @(negedge clk);
    data_req(64'h500, 64'h0, 2'd0, 1'b0);
    respond(64'h0F0F_0F0F_0F0F_0F0F, 1);
    repeat (2) @(negedge clk); #1;
    check("rst_after_pulses", 64'(d_cnt - d0), 64'd1);
    check("rst_after_data", d_last, 64'h0F0F_0F0F_0F0F_0F0F);

    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule
